// File: rtl/ppu_vram_ctrl_if.sv
// Bus bundle for ppu_vram_ctrl: PPU fetch, CPU VRAM access, OAM access and OAM DMA.
// The master side is the PPU/CPU world; the slave side is the memory subsystem.
interface ppu_vram_ctrl_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic [1:0]        mirror_mode;

  logic [ADDR_W-1:0] ppu_addr;
  logic              ppu_rd_en;
  logic [DATA_W-1:0] ppu_rdata;
  logic              ppu_rvalid;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic [7:0]        oam_ppu_addr;
  logic [DATA_W-1:0] oam_ppu_rdata;
  logic [7:0]        oam_cpu_addr;
  logic [DATA_W-1:0] oam_cpu_wdata;
  logic              oam_cpu_we;

  logic              dma_start;
  logic [7:0]        dma_page;
  logic              dma_req;
  logic [15:0]       dma_addr;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;
  logic              dma_busy;
  logic              dma_done;

  modport master (
    output mirror_mode, ppu_addr, ppu_rd_en, cpu_addr, cpu_wdata, cpu_we, cpu_re,
           oam_ppu_addr, oam_cpu_addr, oam_cpu_wdata, oam_cpu_we,
           dma_start, dma_page, dma_rdata, dma_ack,
    input  ppu_rdata, ppu_rvalid, cpu_rdata, cpu_rvalid, oam_ppu_rdata,
           dma_req, dma_addr, dma_busy, dma_done
  );

  modport slave (
    input  mirror_mode, ppu_addr, ppu_rd_en, cpu_addr, cpu_wdata, cpu_we, cpu_re,
           oam_ppu_addr, oam_cpu_addr, oam_cpu_wdata, oam_cpu_we,
           dma_start, dma_page, dma_rdata, dma_ack,
    output ppu_rdata, ppu_rvalid, cpu_rdata, cpu_rvalid, oam_ppu_rdata,
           dma_req, dma_addr, dma_busy, dma_done
  );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// PPU memory subsystem: CHR RAM, mirrored CIRAM, palette RAM, OAM and a 256-byte OAM DMA engine.
// Define PPU_VRAM_FOUR_SCREEN_EN for a 4 KiB four-screen CIRAM that ignores mirror_mode.
module ppu_vram_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int PAT_BYTES = 8192,
  parameter int PAL_BYTES = 32,
  parameter int OAM_DEPTH = 256
) (
  input logic           clk,
  input logic           rst,
  ppu_vram_ctrl_if.slave bus
);

`ifdef PPU_VRAM_FOUR_SCREEN_EN
  localparam int NT_BYTES = 4096;
`else
  localparam int NT_BYTES = 2048;
`endif
  localparam int PAT_AW = $clog2(PAT_BYTES);
  localparam int NT_AW  = $clog2(NT_BYTES);
  localparam int PAL_AW = $clog2(PAL_BYTES);

  typedef enum logic [1:0] {REG_PAT, REG_NT, REG_PAL} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} dma_state_e;

  logic [DATA_W-1:0] pat_mem [PAT_BYTES];
  logic [DATA_W-1:0] nt_mem  [NT_BYTES];
  logic [5:0]        pal_mem [PAL_BYTES];
  logic [DATA_W-1:0] oam_mem [OAM_DEPTH];

  function automatic region_e decode(input logic [ADDR_W-1:0] a);
    if (!a[ADDR_W-1])              return REG_PAT;
    else if (a[ADDR_W-1:8] == 6'h3F) return REG_PAL;
    else                           return REG_NT;
  endfunction

  function automatic logic [NT_AW-1:0] nt_index(input logic [ADDR_W-1:0] a,
                                                input logic [1:0] mode);
`ifdef PPU_VRAM_FOUR_SCREEN_EN
    return a[NT_AW-1:0];
`else
    logic a10;
    case (mode)
      2'd0:    a10 = a[11];
      2'd1:    a10 = a[10];
      2'd2:    a10 = 1'b0;
      default: a10 = 1'b1;
    endcase
    return {a10, a[9:0]};
`endif
  endfunction

  // Sprite backdrop entries $3F10/14/18/1C alias the background backdrop entries.
  function automatic logic [PAL_AW-1:0] pal_index(input logic [ADDR_W-1:0] a);
    logic [PAL_AW-1:0] idx;
    idx = a[PAL_AW-1:0];
    if (idx[4] && (idx[1:0] == 2'b00)) idx[4] = 1'b0;
    return idx;
  endfunction

  region_e           ppu_region, cpu_region;
  logic [NT_AW-1:0]  ppu_nt_idx, cpu_nt_idx;
  logic [PAL_AW-1:0] ppu_pal_idx, cpu_pal_idx;
  logic [DATA_W-1:0] ppu_mem_data, cpu_mem_data;

  logic [DATA_W-1:0] ppu_rdata_q, ppu_rdata_d;
  logic              ppu_rvalid_q, ppu_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] oam_ppu_rdata_q, oam_ppu_rdata_d;

  dma_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        page_q, page_d;
  logic [7:0]        base_q, base_d;

  logic              oam_we;
  logic [7:0]        oam_waddr;
  logic [DATA_W-1:0] oam_wdata;

  always_comb begin
    ppu_region  = decode(bus.ppu_addr);
    cpu_region  = decode(bus.cpu_addr);
    ppu_nt_idx  = nt_index(bus.ppu_addr, bus.mirror_mode);
    cpu_nt_idx  = nt_index(bus.cpu_addr, bus.mirror_mode);
    ppu_pal_idx = pal_index(bus.ppu_addr);
    cpu_pal_idx = pal_index(bus.cpu_addr);

    ppu_mem_data = '0;
    case (ppu_region)
      REG_PAT: ppu_mem_data = pat_mem[bus.ppu_addr[PAT_AW-1:0]];
      REG_NT:  ppu_mem_data = nt_mem[ppu_nt_idx];
      REG_PAL: ppu_mem_data = {{(DATA_W-6){1'b0}}, pal_mem[ppu_pal_idx]};
      default: ppu_mem_data = '0;
    endcase

    cpu_mem_data = '0;
    case (cpu_region)
      REG_PAT: cpu_mem_data = pat_mem[bus.cpu_addr[PAT_AW-1:0]];
      REG_NT:  cpu_mem_data = nt_mem[cpu_nt_idx];
      REG_PAL: cpu_mem_data = {{(DATA_W-6){1'b0}}, pal_mem[cpu_pal_idx]};
      default: cpu_mem_data = '0;
    endcase
  end

  // Reads sample the array before this edge's write, so a same-cycle collision returns old data.
  always_comb begin
    ppu_rvalid_d    = bus.ppu_rd_en;
    ppu_rdata_d     = bus.ppu_rd_en ? ppu_mem_data : ppu_rdata_q;
    cpu_rvalid_d    = bus.cpu_re && !bus.cpu_we;
    cpu_rdata_d     = cpu_rvalid_d ? cpu_mem_data : cpu_rdata_q;
    oam_ppu_rdata_d = oam_mem[bus.oam_ppu_addr];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
    base_d    = base_q;
    oam_we    = 1'b0;
    oam_waddr = bus.oam_cpu_addr;
    oam_wdata = bus.oam_cpu_wdata;

    case (state_q)
      ST_IDLE: begin
        oam_we = bus.oam_cpu_we;
        if (bus.dma_start) begin
          state_d = ST_REQ;
          page_d  = bus.dma_page;
          base_d  = bus.oam_cpu_addr;
          cnt_d   = 8'd0;
        end
      end
      ST_REQ: begin
        if (bus.dma_ack) begin
          oam_we    = 1'b1;
          oam_waddr = base_q + cnt_q;
          oam_wdata = bus.dma_rdata;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q == 8'(OAM_DEPTH - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.cpu_we) begin
      case (cpu_region)
        REG_PAT: pat_mem[bus.cpu_addr[PAT_AW-1:0]] <= bus.cpu_wdata;
        REG_NT:  nt_mem[cpu_nt_idx]                <= bus.cpu_wdata;
        REG_PAL: pal_mem[cpu_pal_idx]              <= bus.cpu_wdata[5:0];
        default: ;
      endcase
    end
    if (oam_we) oam_mem[oam_waddr] <= oam_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ppu_rdata_q     <= '0;
      ppu_rvalid_q    <= 1'b0;
      cpu_rdata_q     <= '0;
      cpu_rvalid_q    <= 1'b0;
      oam_ppu_rdata_q <= '0;
      state_q         <= ST_IDLE;
      cnt_q           <= 8'd0;
      page_q          <= 8'd0;
      base_q          <= 8'd0;
    end else begin
      ppu_rdata_q     <= ppu_rdata_d;
      ppu_rvalid_q    <= ppu_rvalid_d;
      cpu_rdata_q     <= cpu_rdata_d;
      cpu_rvalid_q    <= cpu_rvalid_d;
      oam_ppu_rdata_q <= oam_ppu_rdata_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      page_q          <= page_d;
      base_q          <= base_d;
    end
  end

  assign bus.ppu_rdata     = ppu_rdata_q;
  assign bus.ppu_rvalid    = ppu_rvalid_q;
  assign bus.cpu_rdata     = cpu_rdata_q;
  assign bus.cpu_rvalid    = cpu_rvalid_q;
  assign bus.oam_ppu_rdata = oam_ppu_rdata_q;
  assign bus.dma_req       = (state_q == ST_REQ);
  assign bus.dma_addr      = (state_q == ST_REQ) ? {page_q, cnt_q} : 16'h0000;
  assign bus.dma_busy      = (state_q != ST_IDLE);
  assign bus.dma_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Directed bench for ppu_vram_ctrl: mirroring, palette aliasing, port collisions and OAM DMA
// including a reset that lands in the middle of a transfer.
module tb_ppu_vram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks_total  = 0;
  int   checks_passed = 0;
  int   checks_failed = 0;

  ppu_vram_ctrl_if bus ();

  ppu_vram_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One CPU-port cycle; returns at the next falling edge with the registered result visible.
  task automatic applyStimulus(input logic we, input logic re, input logic [13:0] addr,
                               input logic [7:0] wdata);
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  task automatic cpu_read_check(input string tag, input logic [13:0] addr,
                                input logic [7:0] expected);
    applyStimulus(1'b0, 1'b1, addr, 8'h00);
    checkOutput({tag, "_rvalid"}, {31'd0, bus.cpu_rvalid}, 32'd1);
    checkOutput(tag, {24'd0, bus.cpu_rdata}, {24'd0, expected});
  endtask

  task automatic ppu_read_check(input string tag, input logic [13:0] addr,
                                input logic [7:0] expected);
    bus.ppu_addr  = addr;
    bus.ppu_rd_en = 1'b1;
    @(negedge clk);
    bus.ppu_rd_en = 1'b0;
    checkOutput({tag, "_rvalid"}, {31'd0, bus.ppu_rvalid}, 32'd1);
    checkOutput(tag, {24'd0, bus.ppu_rdata}, {24'd0, expected});
  endtask

  task automatic oam_read_check(input string tag, input logic [7:0] idx,
                                input logic [7:0] expected);
    bus.oam_ppu_addr = idx;
    @(negedge clk);
    checkOutput(tag, {24'd0, bus.oam_ppu_rdata}, {24'd0, expected});
  endtask

  // Serves DMA requests with ack on two of every three cycles; stops early at stop_after acks.
  task automatic run_dma(input int stop_after, input logic [7:0] mask, input bit collide,
                         output int acks, output int done_cycles, output int bad_addr,
                         output bit reached_idle);
    acks = 0;
    done_cycles = 0;
    bad_addr = 0;
    reached_idle = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      bus.dma_ack    = 1'b0;
      bus.dma_start  = 1'b0;
      bus.oam_cpu_we = 1'b0;
      if (bus.dma_done) done_cycles++;
      if (!bus.dma_busy) begin
        reached_idle = 1'b1;
        break;
      end
      if (acks == stop_after) break;
      if (bus.dma_req && (cyc % 3) != 1) begin
        if (bus.dma_addr !== {8'h02, acks[7:0]}) bad_addr++;
        bus.dma_ack   = 1'b1;
        bus.dma_rdata = bus.dma_addr[7:0] ^ mask;
        acks++;
        if (collide && acks == 250) begin
          bus.oam_cpu_addr  = 8'h05;
          bus.oam_cpu_wdata = 8'h77;
          bus.oam_cpu_we    = 1'b1;
          bus.dma_page      = 8'h33;
          bus.dma_start     = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int acks, done_cycles, bad_addr;
    bit reached_idle;

    bus.mirror_mode   = 2'd0;
    bus.ppu_addr      = '0;
    bus.ppu_rd_en     = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_we        = 1'b0;
    bus.cpu_re        = 1'b0;
    bus.oam_ppu_addr  = '0;
    bus.oam_cpu_addr  = '0;
    bus.oam_cpu_wdata = '0;
    bus.oam_cpu_we    = 1'b0;
    bus.dma_start     = 1'b0;
    bus.dma_page      = '0;
    bus.dma_rdata     = '0;
    bus.dma_ack       = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_ppu_rvalid", {31'd0, bus.ppu_rvalid}, 32'd0);
    checkOutput("rst_ppu_rdata", {24'd0, bus.ppu_rdata}, 32'd0);
    checkOutput("rst_cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    checkOutput("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    checkOutput("rst_oam_rdata", {24'd0, bus.oam_ppu_rdata}, 32'd0);
    checkOutput("rst_dma_busy", {31'd0, bus.dma_busy}, 32'd0);
    checkOutput("rst_dma_req", {31'd0, bus.dma_req}, 32'd0);
    checkOutput("rst_dma_done", {31'd0, bus.dma_done}, 32'd0);
    checkOutput("rst_dma_addr", {16'd0, bus.dma_addr}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] horizontal mirroring");
    bus.mirror_mode = 2'd0;
    applyStimulus(1'b1, 1'b0, 14'h2005, 8'hAA);
    applyStimulus(1'b1, 1'b0, 14'h2805, 8'hBB);
    cpu_read_check("horiz_2405", 14'h2405, 8'hAA);
    cpu_read_check("horiz_2C05", 14'h2C05, 8'hBB);
    cpu_read_check("horiz_3405", 14'h3405, 8'hAA);
    ppu_read_check("horiz_ppu_2C05", 14'h2C05, 8'hBB);
    @(negedge clk);
    checkOutput("ppu_rvalid_pulse", {31'd0, bus.ppu_rvalid}, 32'd0);
    checkOutput("ppu_rdata_hold", {24'd0, bus.ppu_rdata}, 32'h0000_00BB);

    $display("[TB] vertical and single-screen mirroring");
    bus.mirror_mode = 2'd1;
    applyStimulus(1'b1, 1'b0, 14'h2405, 8'h22);
    applyStimulus(1'b1, 1'b0, 14'h2005, 8'h11);
    cpu_read_check("vert_2805", 14'h2805, 8'h11);
    cpu_read_check("vert_2405", 14'h2405, 8'h22);
    bus.mirror_mode = 2'd2;
    ppu_read_check("single_lo_2C05", 14'h2C05, 8'h11);
    bus.mirror_mode = 2'd3;
    ppu_read_check("single_hi_2005", 14'h2005, 8'h22);

    $display("[TB] palette");
    applyStimulus(1'b1, 1'b0, 14'h3F10, 8'h35);
    cpu_read_check("pal_3F00", 14'h3F00, 8'h35);
    @(negedge clk);
    checkOutput("cpu_rvalid_pulse", {31'd0, bus.cpu_rvalid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 14'h3F01, 8'hFF);
    cpu_read_check("pal_3F21", 14'h3F21, 8'h3F);
    applyStimulus(1'b1, 1'b0, 14'h3F04, 8'h12);
    ppu_read_check("pal_3F14", 14'h3F14, 8'h12);

    $display("[TB] pattern RAM and port collisions");
    applyStimulus(1'b1, 1'b0, 14'h1234, 8'h5C);
    ppu_read_check("pat_ppu_1234", 14'h1234, 8'h5C);
    cpu_read_check("pat_cpu_1234", 14'h1234, 8'h5C);
    applyStimulus(1'b1, 1'b1, 14'h0100, 8'h9D);
    checkOutput("we_re_rvalid", {31'd0, bus.cpu_rvalid}, 32'd0);
    checkOutput("we_re_rdata_hold", {24'd0, bus.cpu_rdata}, 32'h0000_005C);
    cpu_read_check("we_re_written", 14'h0100, 8'h9D);
    bus.ppu_addr  = 14'h0100;
    bus.ppu_rd_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 14'h0100, 8'hE1);
    bus.ppu_rd_en = 1'b0;
    checkOutput("collide_old_data", {24'd0, bus.ppu_rdata}, 32'h0000_009D);
    cpu_read_check("collide_new_data", 14'h0100, 8'hE1);

    $display("[TB] full OAM DMA with collision");
    bus.oam_cpu_addr = 8'h10;
    bus.dma_page     = 8'h02;
    bus.dma_start    = 1'b1;
    run_dma(100000, 8'h00, 1'b1, acks, done_cycles, bad_addr, reached_idle);
    checkOutput("dma_ack_count", acks, 32'd256);
    checkOutput("dma_done_cycles", done_cycles, 32'd1);
    checkOutput("dma_addr_seq", bad_addr, 32'd0);
    checkOutput("dma_idle_after", {31'd0, reached_idle}, 32'd1);
    checkOutput("dma_busy_after", {31'd0, bus.dma_busy}, 32'd0);
    checkOutput("dma_req_after", {31'd0, bus.dma_req}, 32'd0);
    oam_read_check("oam_10", 8'h10, 8'h00);
    oam_read_check("oam_0F", 8'h0F, 8'hFF);
    oam_read_check("oam_05_dma_wins", 8'h05, 8'hF5);
    oam_read_check("oam_80", 8'h80, 8'h70);

    $display("[TB] idle OAM write then reset mid-DMA");
    bus.oam_cpu_addr  = 8'h38;
    bus.oam_cpu_wdata = 8'h5A;
    bus.oam_cpu_we    = 1'b1;
    @(negedge clk);
    bus.oam_cpu_we = 1'b0;
    oam_read_check("oam_38_cpu", 8'h38, 8'h5A);
    bus.oam_cpu_addr = 8'h10;
    bus.dma_page     = 8'h02;
    bus.dma_start    = 1'b1;
    run_dma(40, 8'hC3, 1'b0, acks, done_cycles, bad_addr, reached_idle);
    checkOutput("rdma_ack_count", acks, 32'd40);
    checkOutput("rdma_busy_before", {31'd0, bus.dma_busy}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rdma_busy", {31'd0, bus.dma_busy}, 32'd0);
    checkOutput("rdma_req", {31'd0, bus.dma_req}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rdma_busy_after_rst", {31'd0, bus.dma_busy}, 32'd0);
    oam_read_check("rdma_oam_10", 8'h10, 8'hC3);
    oam_read_check("rdma_oam_37", 8'h37, 8'hE4);
    oam_read_check("rdma_oam_38_kept", 8'h38, 8'h5A);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
